// File: rtl/async_fifo_wr_ctrl.sv
// Write-side pointer/flag controller of the async FIFO, clocked entirely on CLK.
// Optional almost-full output W_AFULL is built when ALMOST_FULL_EN is defined.
module async_fifo_wr_ctrl #(
    parameter int ADDR_WD  = 3,
    parameter int AF_LEVEL = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               W_INC,
    input  logic [ADDR_WD:0]   WQ2_RPTR,
    input  logic               W_OVF_CLR,
    output logic               W_EN,
    output logic [ADDR_WD-1:0] W_ADDR,
    output logic [ADDR_WD:0]   W_PTR,
    output logic               W_FULL,
    output logic [ADDR_WD:0]   W_LEVEL,
`ifdef ALMOST_FULL_EN
    output logic               W_AFULL,
`endif
    output logic               W_OVF
);

    logic [ADDR_WD:0] wbin_q, wbin_d;
    logic [ADDR_WD:0] wptr_q, wptr_d;
    logic [ADDR_WD:0] level_q, level_d;
    logic [ADDR_WD:0] rbin;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic             w_en;

    always_comb begin
        w_en   = W_INC & ~full_q;
        wbin_d = wbin_q + {{ADDR_WD{1'b0}}, w_en};
        wptr_d = wbin_d ^ (wbin_d >> 1);
        // Full when the next write pointer laps the read pointer: top two Gray bits differ.
        full_d = (wptr_d == {~WQ2_RPTR[ADDR_WD:ADDR_WD-1], WQ2_RPTR[ADDR_WD-2:0]});
        rbin          = '0;
        rbin[ADDR_WD] = WQ2_RPTR[ADDR_WD];
        for (int i = ADDR_WD - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ WQ2_RPTR[i];
        end
        level_d = wbin_d - rbin;
        // A same-cycle overflow beats the clear.
        ovf_d   = (W_INC & full_q) | (ovf_q & ~W_OVF_CLR);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wbin_q  <= '0;
            wptr_q  <= '0;
            full_q  <= 1'b0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wptr_q  <= wptr_d;
            full_q  <= full_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef ALMOST_FULL_EN
    localparam logic [ADDR_WD:0] AF_TH = (ADDR_WD+1)'(AF_LEVEL);
    logic afull_q, afull_d;

    always_comb begin
        afull_d = (level_d >= AF_TH);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) afull_q <= 1'b0;
        else      afull_q <= afull_d;
    end

    assign W_AFULL = afull_q;
`endif

    assign W_EN    = w_en;
    assign W_ADDR  = wbin_q[ADDR_WD-1:0];
    assign W_PTR   = wptr_q;
    assign W_FULL  = full_q;
    assign W_LEVEL = level_q;
    assign W_OVF   = ovf_q;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed bench for async_fifo_wr_ctrl (ADDR_WD=3, AF_LEVEL=6).
module tb_async_fifo_wr_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       W_INC = 1'b0;
    logic [3:0] WQ2_RPTR = '0;
    logic       W_OVF_CLR = 1'b0;
    logic       W_EN;
    logic [2:0] W_ADDR;
    logic [3:0] W_PTR;
    logic       W_FULL;
    logic [3:0] W_LEVEL;
    logic       W_OVF;
`ifdef ALMOST_FULL_EN
    logic       W_AFULL;
`endif

    int n_vec = 0;
    int n_err = 0;

    async_fifo_wr_ctrl #(.ADDR_WD(3), .AF_LEVEL(6)) dut (
        .CLK(CLK), .RST(RST), .W_INC(W_INC), .WQ2_RPTR(WQ2_RPTR),
        .W_OVF_CLR(W_OVF_CLR), .W_EN(W_EN), .W_ADDR(W_ADDR), .W_PTR(W_PTR),
        .W_FULL(W_FULL), .W_LEVEL(W_LEVEL),
`ifdef ALMOST_FULL_EN
        .W_AFULL(W_AFULL),
`endif
        .W_OVF(W_OVF)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge; return at the following falling edge.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        W_INC = 0; W_OVF_CLR = 0; WQ2_RPTR = '0;
        RST = 0;
        tick();
        RST = 1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_ptr", W_PTR, 4'h0);
        chk("rst_full", W_FULL, 1'b0);
        chk("rst_level", W_LEVEL, 4'd0);
        chk("rst_ovf", W_OVF, 1'b0);
        chk("rst_addr", W_ADDR, 3'd0);

        // Fill: 8 writes
        for (int i = 0; i < 8; i++) begin
            W_INC = 1;
            #1;
            chk($sformatf("fill_addr%0d", i), W_ADDR, i[2:0]);
            chk($sformatf("fill_en%0d", i), W_EN, 1'b1);
            tick();
        end
        chk("fill_ptr", W_PTR, 4'b1100);
        chk("fill_level", W_LEVEL, 4'd8);
        chk("fill_full", W_FULL, 1'b1);

        // Overflow while full
        W_INC = 1;
        #1;
        chk("ovf_en", W_EN, 1'b0);
        tick();
        chk("ovf_ptr_hold", W_PTR, 4'b1100);
        chk("ovf_addr_hold", W_ADDR, 3'd0);
        chk("ovf_set", W_OVF, 1'b1);
        W_INC = 0; W_OVF_CLR = 1;
        tick();
        chk("ovf_clr", W_OVF, 1'b0);
        W_INC = 1; W_OVF_CLR = 1;
        tick();
        chk("ovf_set_wins", W_OVF, 1'b1);
        W_INC = 0; W_OVF_CLR = 1;
        tick();
        chk("ovf_clr2", W_OVF, 1'b0);
        W_OVF_CLR = 0;

        // Drain one entry via read pointer
        WQ2_RPTR = 4'b0001;
        tick();
        chk("drain_full", W_FULL, 1'b0);
        chk("drain_level", W_LEVEL, 4'd7);
        W_INC = 1;
        tick();
        W_INC = 0;
        chk("refill_full", W_FULL, 1'b1);
        chk("refill_ptr", W_PTR, 4'b1101);
        chk("refill_level", W_LEVEL, 4'd8);

        // Async reset mid-burst
        do_reset();
        W_INC = 1;
        tick(); tick(); tick();
        chk("burst_ptr", W_PTR, gray(4'd3));
        #2;
        RST = 0;
        #1;
        chk("midrst_ptr", W_PTR, 4'h0);
        chk("midrst_full", W_FULL, 1'b0);
        chk("midrst_level", W_LEVEL, 4'd0);
        chk("midrst_ovf", W_OVF, 1'b0);
        W_INC = 0;
        @(negedge CLK);
        RST = 1;

        // Wrap: 20 writes with read pointer two behind
        for (int k = 1; k <= 20; k++) begin
            W_INC = 1;
            WQ2_RPTR = (k >= 3) ? gray(4'((k - 2) & 15)) : 4'h0;
            tick();
            chk($sformatf("wrap_level%0d", k), W_LEVEL, (k >= 2) ? 4'd2 : 4'd1);
            chk($sformatf("wrap_full%0d", k), W_FULL, 1'b0);
            if (k == 15) chk("wrap_ptr15", W_PTR, 4'b1000);
            if (k == 16) begin
                chk("wrap_ptr16", W_PTR, 4'b0000);
                chk("wrap_addr16", W_ADDR, 3'd0);
            end
        end
        W_INC = 0;

`ifdef ALMOST_FULL_EN
        do_reset();
        chk("af_rst", W_AFULL, 1'b0);
        W_INC = 1;
        for (int i = 0; i < 5; i++) tick();
        chk("af_5", W_AFULL, 1'b0);
        tick();
        chk("af_6", W_AFULL, 1'b1);
        W_INC = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
